// File: rtl/file_source_pkg.sv
// file_source_pkg: shared types, an in-memory text file store, and the row parser
// for the file_source stimulus block.
// parse_row pulls one logical row (blank lines skipped) from an open file handle.
// It splits the row into comma-separated decimal integers, each kept as a 32-bit value.
package file_source_pkg;

  // Longest text line, in characters, that one row may occupy.
  localparam int MAX_LINE  = 1024;
  // Upper bound on lanes per row supported by the parser's value buffer.
  localparam int MAX_LANES = 64;

  typedef enum logic [1:0] {
    ROW_OK,
    ROW_EOF,
    ROW_BAD
  } row_status_t;

  typedef logic [MAX_LANES-1:0][31:0] row_vals_t;

  // In-memory text files keyed by name, and open handles with read positions.
  string vfs_text [string];
  string vfs_name [int];
  int    vfs_pos  [int];
  int    vfs_next_fd = 1;

  // Replace the whole content of a named file.
  function automatic void vfs_write(input string name, input string text);
    vfs_text[name] = text;
  endfunction

  // Open a named file for reading; 0 when it does not exist.
  function automatic int vfs_open(input string name);
    int fd;
    if (!vfs_text.exists(name)) return 0;
    fd = vfs_next_fd;
    vfs_next_fd = vfs_next_fd + 1;
    vfs_name[fd] = name;
    vfs_pos[fd]  = 0;
    return fd;
  endfunction

  function automatic void vfs_close(input int fd);
    if (vfs_name.exists(fd)) vfs_name.delete(fd);
    if (vfs_pos.exists(fd))  vfs_pos.delete(fd);
  endfunction

  function automatic void vfs_rewind(input int fd);
    if (vfs_pos.exists(fd)) vfs_pos[fd] = 0;
  endfunction

  // Read one line (including its '\n') into line; returns its length, 0 at end of file.
  function automatic int vfs_gets(input int fd, output string line);
    string t;
    int    p;
    int    k;
    line = "";
    if (!vfs_name.exists(fd)) return 0;
    if (!vfs_text.exists(vfs_name[fd])) return 0;
    t = vfs_text[vfs_name[fd]];
    p = vfs_pos[fd];
    if (p >= t.len()) return 0;
    k = p;
    while (k < t.len() && t[k] != 8'h0a && (k - p) < MAX_LINE) k++;
    if (k < t.len() && t[k] == 8'h0a) k++;
    line = t.substr(p, k - 1);
    vfs_pos[fd] = k;
    return k - p;
  endfunction

  // Read the next non-blank line from fd and parse up to n integers out of it.
  // ROW_EOF: nothing left in the file. ROW_BAD: fewer than n well-formed fields.
  // Values wrap modulo 2^32, so a 32-bit two's complement result always comes back.
  function automatic row_status_t parse_row(input int fd, input int n, output row_vals_t vals);
    string                 line;
    logic [7:0]            c;
    logic [31:0]           acc;
    int                    cnt;
    int                    fields;
    logic                  neg;
    logic                  sign_seen;
    logic                  have_digit;
    logic                  blank;
    logic                  bad;
    logic                  done;
    row_status_t           st;

    vals = '0;
    st   = ROW_EOF;
    done = 1'b0;
    while (!done) begin
      cnt = vfs_gets(fd, line);
      if (cnt <= 0) begin
        st   = ROW_EOF;
        done = 1'b1;
      end else begin
        fields     = 0;
        acc        = '0;
        neg        = 1'b0;
        sign_seen  = 1'b0;
        have_digit = 1'b0;
        blank      = 1'b1;
        bad        = 1'b0;
        vals       = '0;
        for (int i = 0; i < cnt; i++) begin
          c = line[i];
          if (c == 8'h20 || c == 8'h09 || c == 8'h0d || c == 8'h0a) begin
            // whitespace and line terminators carry no data
          end else begin
            blank = 1'b0;
            if (c == "-" || c == "+") begin
              if (have_digit || sign_seen) bad = 1'b1;
              sign_seen = 1'b1;
              neg       = (c == "-");
            end else if (c >= "0" && c <= "9") begin
              acc        = acc * 32'd10 + {24'd0, c - 8'd48};
              have_digit = 1'b1;
            end else if (c == ",") begin
              if (!have_digit) begin
                bad = 1'b1;
              end else begin
                if (fields < MAX_LANES) vals[fields] = neg ? -acc : acc;
                fields = fields + 1;
              end
              acc        = '0;
              neg        = 1'b0;
              sign_seen  = 1'b0;
              have_digit = 1'b0;
            end else begin
              bad = 1'b1;
            end
          end
        end
        // The last field on the line has no trailing comma.
        if (have_digit) begin
          if (fields < MAX_LANES) vals[fields] = neg ? -acc : acc;
          fields = fields + 1;
        end else if (sign_seen) begin
          bad = 1'b1;
        end
        if (!blank) begin
          done = 1'b1;
          st   = (bad || fields < n) ? ROW_BAD : ROW_OK;
        end
      end
    end
    return st;
  endfunction

endpackage

// File: rtl/file_source_if.sv
// file_source_if: enable in, parallel signed lanes out.
// master = the file source, slave = the consumer that raises en and takes the lanes.
interface file_source_if #(
  parameter int OUT_WIDTH = 16,
  parameter int OUT_NUM   = 8
);
  logic                        en;
  logic signed [OUT_WIDTH-1:0] dataOut [OUT_NUM];

  modport master (input en, output dataOut);
  modport slave  (output en, input dataOut);
endinterface

// File: rtl/file_source_reader.sv
// file_source_reader: owns the file handle, opens it lazily on the first request,
// parses one row per request and holds it as 32-bit values.
// When rewind is high, an end of file seeks back to the start and re-reads row 0 on the same edge.
// Optional macro FILE_SOURCE_WARN_EN enables notes on rewind/end of file and warnings on short rows.
module file_source_reader
  import file_source_pkg::*;
#(
  parameter string FILE_NAME = "out.log",
  parameter int    OUT_NUM   = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    req,
  input  logic                    rewind,
  output logic [OUT_NUM-1:0][31:0] row,
  output logic                    valid
);

  // Whole reader state in one register so each request updates it atomically.
  typedef struct packed {
    logic [31:0]              fd;
    logic [31:0]              row_num;
    logic                     at_end;
    logic                     valid;
    logic [OUT_NUM-1:0][31:0] vals;
  } rd_state_t;

  rd_state_t rd_reg;

  // One request: open if needed, read a row, rewind on end of file when allowed.
  // Returns the new state. The held row is kept when nothing usable is read.
  function automatic rd_state_t fetch(input rd_state_t cur, input logic rw);
    rd_state_t   nxt;
    row_vals_t   v;
    row_status_t s;
    int          fd;

    nxt = cur;
    if (cur.at_end && !rw) return cur;

    fd = int'(cur.fd);
    if (fd == 0) begin
      fd = vfs_open(FILE_NAME);
      if (fd == 0) $fatal(1, "file_source: cannot open %s", FILE_NAME);
      nxt.row_num = '0;
    end

    s = parse_row(fd, OUT_NUM, v);
`ifdef FILE_SOURCE_WARN_EN
    if (s == ROW_BAD)
      $warning("file_source: short or malformed row %0d in %s", nxt.row_num, FILE_NAME);
`endif

    if (s != ROW_OK && rw) begin
`ifdef FILE_SOURCE_WARN_EN
      $display("file_source: end of %s, rewinding to row 0", FILE_NAME);
`endif
      vfs_rewind(fd);
      nxt.row_num = '0;
      s = parse_row(fd, OUT_NUM, v);
`ifdef FILE_SOURCE_WARN_EN
      if (s == ROW_BAD)
        $warning("file_source: short or malformed row %0d in %s", nxt.row_num, FILE_NAME);
`endif
    end

    if (s == ROW_OK) begin
      nxt.vals    = v[OUT_NUM-1:0];
      nxt.valid   = 1'b1;
      nxt.at_end  = 1'b0;
      nxt.row_num = nxt.row_num + 32'd1;
    end else begin
      // Nothing usable: keep the last row and stop advancing.
      nxt.at_end = 1'b1;
`ifdef FILE_SOURCE_WARN_EN
      if (!rw) $display("file_source: end of %s, holding last row", FILE_NAME);
`endif
    end
    nxt.fd = fd;
    return nxt;
  endfunction

  // Reset closes the file and forgets the position; each request advances one row.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      if (rd_reg.fd != 0) vfs_close(int'(rd_reg.fd));
      rd_reg <= '0;
    end else if (req) begin
      rd_reg <= fetch(rd_reg, rewind);
    end
  end

  assign row   = rd_reg.vals;
  assign valid = rd_reg.valid;

endmodule

// File: rtl/file_source.sv
// file_source: simulation-only stimulus source. Streams rows of comma-separated integers
// from FILE_NAME onto OUT_NUM signed lanes, one row per enabled clock, latency one edge.
// CYCLE=1 loops the file without a bubble; CYCLE=0 holds the last row at end of file.
// Optional macro FILE_SOURCE_WARN_EN: notes on rewind/end of file, warnings on short rows.
module file_source
  import file_source_pkg::*;
#(
  parameter string FILE_NAME = "out.log",
  parameter int    OUT_WIDTH = 16,
  parameter int    OUT_NUM   = 8,
  parameter int    CYCLE     = 1
) (
  input  logic          clk,
  input  logic          rst,
  file_source_if.master bus
);

  logic [OUT_NUM-1:0][31:0] row;
  logic                     valid;

  file_source_reader #(
    .FILE_NAME (FILE_NAME),
    .OUT_NUM   (OUT_NUM)
  ) u_reader (
    .clk    (clk),
    .rst    (rst),
    .req    (bus.en),
    .rewind (CYCLE != 0),
    .row    (row),
    .valid  (valid)
  );

  // Each lane keeps the low OUT_WIDTH bits of its registered 32-bit value as two's complement.
  generate
    for (genvar gi = 0; gi < OUT_NUM; gi++) begin : g_lane
      assign bus.dataOut[gi] = valid ? row[gi][OUT_WIDTH-1:0] : '0;
    end
  endgenerate

endmodule

// File: tb/tb_file_source.sv
// tb_file_source: directed checks of file_source with three instances:
// an 8-lane looping ramp, an 8-lane hold-at-end file, and a 2-lane looping wrap file.
module tb_file_source;

  logic clk;
  logic rst;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  file_source_if #(.OUT_WIDTH(16), .OUT_NUM(8)) bus_ramp ();
  file_source_if #(.OUT_WIDTH(16), .OUT_NUM(8)) bus_hold ();
  file_source_if #(.OUT_WIDTH(16), .OUT_NUM(2)) bus_wrap ();

  file_source #(.FILE_NAME("fs_ramp.txt"), .OUT_WIDTH(16), .OUT_NUM(8), .CYCLE(1)) u_ramp (
    .clk (clk), .rst (rst), .bus (bus_ramp));
  file_source #(.FILE_NAME("fs_hold.txt"), .OUT_WIDTH(16), .OUT_NUM(8), .CYCLE(0)) u_hold (
    .clk (clk), .rst (rst), .bus (bus_hold));
  file_source #(.FILE_NAME("fs_wrap.txt"), .OUT_WIDTH(16), .OUT_NUM(2), .CYCLE(1)) u_wrap (
    .clk (clk), .rst (rst), .bus (bus_wrap));

  int ramp_act [8];
  int hold_act [8];
  int wrap_act [2];

  always_comb begin
    for (int j = 0; j < 8; j++) begin
      ramp_act[j] = int'(bus_ramp.dataOut[j]);
      hold_act[j] = int'(bus_hold.dataOut[j]);
    end
    for (int j = 0; j < 2; j++) wrap_act[j] = int'(bus_wrap.dataOut[j]);
  end

  int n_vec = 0;
  int n_bad = 0;

  typedef struct {
    logic en;
    int   exp [8];
  } vec_t;

  function automatic int s16(input int v);
    logic [15:0] lo;
    lo = v[15:0];
    return int'($signed(lo));
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // sel: 0 ramp, 1 hold, 2 wrap; only the first n lanes are compared.
  task automatic check(input string nm, input int sel, input int n, input int exp [8]);
    int act [8];
    int bad_lane;
    bad_lane = -1;
    for (int j = 0; j < 8; j++) begin
      act[j] = 0;
      if (j < n) begin
        case (sel)
          0:       act[j] = ramp_act[j];
          1:       act[j] = hold_act[j];
          default: act[j] = wrap_act[j % 2];
        endcase
      end
    end
    for (int j = 0; j < n; j++)
      if (act[j] != exp[j] && bad_lane < 0) bad_lane = j;
    n_vec++;
    if (bad_lane >= 0) begin
      n_bad++;
      $display("FAIL %s: lane %0d got %0d, expected %0d", nm, bad_lane, act[bad_lane], exp[bad_lane]);
    end else begin
      $display("vec %-16s ok: %0d %0d %0d %0d %0d %0d %0d %0d", nm,
               act[0], act[1], act[2], act[3], act[4], act[5], act[6], act[7]);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "tb_file_source timeout");
  end

  initial begin
    string txt;
    int    zero8 [8];
    int    row_a [8];
    int    row_b [8];
    int    row_c [8];
    int    e     [8];
    vec_t  tbl   [10];
    int    wrap_exp [5][2];

    zero8 = '{0, 0, 0, 0, 0, 0, 0, 0};
    row_a = '{1, -2, 3, 4, 5, 6, 7, 8};
    row_b = '{100, 200, 300, 400, 500, 600, 700, 32767};
    row_c = '{-1, -100, -32768, 0, -1, 0, -32768, 7};

    // en sequence for the hold-at-end instance: toggling, then running past the short row.
    tbl[0].en = 1'b0; tbl[0].exp = zero8;
    tbl[1].en = 1'b1; tbl[1].exp = row_a;
    tbl[2].en = 1'b0; tbl[2].exp = row_a;
    tbl[3].en = 1'b0; tbl[3].exp = row_a;
    tbl[4].en = 1'b1; tbl[4].exp = row_b;
    tbl[5].en = 1'b1; tbl[5].exp = row_c;
    tbl[6].en = 1'b1; tbl[6].exp = row_c;
    tbl[7].en = 1'b1; tbl[7].exp = row_c;
    tbl[8].en = 1'b0; tbl[8].exp = row_c;
    tbl[9].en = 1'b1; tbl[9].exp = row_c;

    wrap_exp[0] = '{0, -32768};
    wrap_exp[1] = '{7, -1};
    wrap_exp[2] = '{32767, 7};
    wrap_exp[3] = '{0, -32768};
    wrap_exp[4] = '{7, -1};

    rst         = 1'b1;
    bus_ramp.en = 1'b0;
    bus_hold.en = 1'b0;
    bus_wrap.en = 1'b0;

    // Files are written while the sources are held in reset.
    txt = "";
    for (int r = 0; r < 256; r++) begin
      txt = {txt, $sformatf("%0d", 256 * r)};
      for (int j = 1; j < 8; j++) txt = {txt, $sformatf(",%0d", 256 * r + j)};
      txt = {txt, "\n"};
    end
    file_source_pkg::vfs_write("fs_ramp.txt", txt);

    txt = "";
    txt = {txt, " 1,-2, 3,+4,5,6,7,8\n\n"};
    txt = {txt, "100,200,300,400,500,600,700,32767\n"};
    txt = {txt, "-1,-100,-32768,0,65535,65536,32768,65543\n"};
    txt = {txt, "9,9,9\n"};
    txt = {txt, "11,12,13,14,15,16,17,18\n"};
    file_source_pkg::vfs_write("fs_hold.txt", txt);

    file_source_pkg::vfs_write("fs_wrap.txt", "65536,32768\n65543,-1\n -32769,7\n");

    step();
    step();
    rst = 1'b0;

    check("reset ramp", 0, 8, zero8);
    check("reset hold", 1, 8, zero8);
    check("reset wrap", 2, 2, zero8);

    for (int i = 0; i < 10; i++) begin
      bus_hold.en = tbl[i].en;
      step();
      check($sformatf("hold[%0d]", i), 1, 8, tbl[i].exp);
    end
    bus_hold.en = 1'b0;

    bus_wrap.en = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      e = '{wrap_exp[i][0], wrap_exp[i][1], 0, 0, 0, 0, 0, 0};
      check($sformatf("wrap[%0d]", i), 2, 2, e);
    end
    bus_wrap.en = 1'b0;

    // Two full passes of the ramp file; the second must restart at row 0 with no bubble.
    bus_ramp.en = 1'b1;
    for (int p = 0; p < 2; p++) begin
      for (int r = 0; r < 256; r++) begin
        step();
        for (int j = 0; j < 8; j++) e[j] = s16(256 * r + j);
        check($sformatf("ramp p%0d r%0d", p, r), 0, 8, e);
      end
    end
    for (int r = 0; r < 3; r++) begin
      step();
      for (int j = 0; j < 8; j++) e[j] = s16(256 * r + j);
      check($sformatf("ramp p2 r%0d", r), 0, 8, e);
    end

    // Asynchronous reset between edges clears outputs immediately.
    #3;
    rst = 1'b1;
    #1;
    check("rst async ramp", 0, 8, zero8);
    check("rst async hold", 1, 8, zero8);
    step();
    check("rst held ramp", 0, 8, zero8);
    #2;
    rst = 1'b0;
    bus_hold.en = 1'b1;
    step();
    for (int j = 0; j < 8; j++) e[j] = s16(j);
    check("after rst r0", 0, 8, e);
    check("after rst hold", 1, 8, row_a);
    check("after rst wrap", 2, 2, zero8);
    step();
    for (int j = 0; j < 8; j++) e[j] = s16(256 + j);
    check("after rst r1", 0, 8, e);
    bus_ramp.en = 1'b0;
    bus_hold.en = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
